// File: rtl/bp_lce_cmd_ingress.sv
// LCE command ingress FIFO: merges network and loopback commands in order and
// presents them to the LCE with valid->yumi. Optional BP_LCE_CMD_INGRESS_BYPASS_EN.

module bp_lce_cmd_ingress_checker
  (input logic clk_i
  ,input logic reset_n_i
  ,input logic lce_cmd_v_i
  ,input logic lce_cmd_yumi_i
  );

  // The LCE may only consume a command that is being presented.
  yumi_without_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(lce_cmd_yumi_i && !lce_cmd_v_i));

endmodule

module bp_lce_cmd_ingress
  #(parameter int msg_width_p = 0
   ,parameter int els_p = 4
   ,localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
   ,localparam int cnt_width_lp = ((els_p + 1) > 1) ? $clog2(els_p + 1) : 1
   ,localparam int msg_w_lp = (msg_width_p > 0) ? msg_width_p : 1
   )
  (input  logic                    clk_i
  ,input  logic                    reset_n_i

  ,input  logic [msg_w_lp-1:0]     net_cmd_i
  ,input  logic                    net_cmd_v_i
  ,output logic                    net_cmd_ready_and_o

  ,input  logic [msg_w_lp-1:0]     loop_cmd_i
  ,input  logic                    loop_cmd_v_i
  ,output logic                    loop_cmd_ready_and_o

  ,output logic [msg_w_lp-1:0]     lce_cmd_o
  ,output logic                    lce_cmd_v_o
  ,input  logic                    lce_cmd_yumi_i

  ,output logic [cnt_width_lp-1:0] count_o
  ,output logic                    empty_o
  );

  localparam logic [cnt_width_lp-1:0] els_cnt_lp    = cnt_width_lp'(els_p);
  localparam logic [cnt_width_lp-1:0] els_m1_cnt_lp = cnt_width_lp'(els_p - 1);

  logic [lg_els_lp-1:0]    wptr_r, rptr_r;
  logic [cnt_width_lp-1:0] count_r, count_next_s;
  logic                    init_r;
  logic [msg_w_lp-1:0]     mem_r [els_p];

  logic                    net_enq_s, loop_enq_s;
  logic [1:0]              wr_cnt_s;
  logic [msg_w_lp-1:0]     wr0_data_s, wr1_data_s;
  logic                    rd_adv_s;
  logic                    bypass_take_s;

  // Readiness looks only at the pre-dequeue count, never at valids.
  assign net_cmd_ready_and_o  = init_r & (count_r < els_cnt_lp);
  assign loop_cmd_ready_and_o = init_r & (count_r < els_m1_cnt_lp);

  assign net_enq_s  = net_cmd_v_i & net_cmd_ready_and_o;
  assign loop_enq_s = loop_cmd_v_i & loop_cmd_ready_and_o;

  assign count_next_s = count_r
                      + cnt_width_lp'(net_enq_s)
                      + cnt_width_lp'(loop_enq_s)
                      - cnt_width_lp'(lce_cmd_yumi_i);

`ifdef BP_LCE_CMD_INGRESS_BYPASS_EN
  assign bypass_take_s = (count_r == cnt_width_lp'(0)) & (net_enq_s | loop_enq_s) & lce_cmd_yumi_i;
`else
  assign bypass_take_s = 1'b0;
`endif

  // Write-slot selection: network first, loop second; a bypassed command is never stored.
  always_comb begin
    wr0_data_s = net_enq_s ? net_cmd_i : loop_cmd_i;
    wr1_data_s = loop_cmd_i;
    wr_cnt_s   = {1'b0, net_enq_s} + {1'b0, loop_enq_s};
    rd_adv_s   = lce_cmd_yumi_i;
    if (bypass_take_s) begin
      wr0_data_s = loop_cmd_i;
      wr_cnt_s   = {1'b0, net_enq_s & loop_enq_s};
      rd_adv_s   = 1'b0;
    end else begin
      rd_adv_s   = lce_cmd_yumi_i;
    end
  end

  // Head presentation; with bypass, an empty FIFO forwards the incoming command.
  always_comb begin
    lce_cmd_v_o = (count_r != cnt_width_lp'(0));
    lce_cmd_o   = mem_r[rptr_r];
`ifdef BP_LCE_CMD_INGRESS_BYPASS_EN
    if (count_r == cnt_width_lp'(0)) begin
      lce_cmd_v_o = net_enq_s | loop_enq_s;
      lce_cmd_o   = net_enq_s ? net_cmd_i : loop_cmd_i;
    end else begin
      lce_cmd_v_o = 1'b1;
    end
`endif
  end

  assign count_o = count_r;
  assign empty_o = (count_r == cnt_width_lp'(0));

  // Pointer, count and init state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= lg_els_lp'(0);
      rptr_r  <= lg_els_lp'(0);
      count_r <= cnt_width_lp'(0);
      init_r  <= 1'b0;
    end else begin
      wptr_r  <= wptr_r + lg_els_lp'(wr_cnt_s);
      rptr_r  <= rptr_r + lg_els_lp'(rd_adv_s);
      count_r <= count_next_s;
      init_r  <= 1'b1;
    end
  end

  // Storage is intentionally not reset; count_r gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_cnt_s != 2'd0)
      mem_r[wptr_r] <= wr0_data_s;
    if (wr_cnt_s == 2'd2)
      mem_r[wptr_r + lg_els_lp'(1)] <= wr1_data_s;
  end

  bp_lce_cmd_ingress_checker checker_inst
    (.clk_i          (clk_i)
    ,.reset_n_i      (reset_n_i)
    ,.lce_cmd_v_i    (lce_cmd_v_o)
    ,.lce_cmd_yumi_i (lce_cmd_yumi_i)
    );

endmodule

// File: tb/tb_bp_lce_cmd_ingress.sv
// Directed plus random bench for bp_lce_cmd_ingress (default build, els_p=4)
// against a queue-based reference model.

module tb_bp_lce_cmd_ingress;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] net_cmd = 8'h00;
  logic         net_v = 1'b0;
  logic         net_rdy;
  logic [W-1:0] loop_cmd = 8'h00;
  logic         loop_v = 1'b0;
  logic         loop_rdy;
  logic [W-1:0] lce_cmd;
  logic         lce_v;
  logic         yumi = 1'b0;
  logic [2:0]   count;
  logic         empty;

  int total = 0;
  int bad = 0;

  logic [W-1:0] q[$];
  bit           m_init = 1'b0;

  bp_lce_cmd_ingress #(.msg_width_p(W), .els_p(N)) dut
    (.clk_i               (clk)
    ,.reset_n_i           (reset_n)
    ,.net_cmd_i           (net_cmd)
    ,.net_cmd_v_i         (net_v)
    ,.net_cmd_ready_and_o (net_rdy)
    ,.loop_cmd_i          (loop_cmd)
    ,.loop_cmd_v_i        (loop_v)
    ,.loop_cmd_ready_and_o(loop_rdy)
    ,.lce_cmd_o           (lce_cmd)
    ,.lce_cmd_v_o         (lce_v)
    ,.lce_cmd_yumi_i      (yumi)
    ,.count_o             (count)
    ,.empty_o             (empty)
    );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with the model's view of the buffer.
  task automatic check_outputs(input string ctx);
    check({ctx, ".v"},        32'(lce_v),   32'(q.size() != 0));
    if (q.size() != 0)
      check({ctx, ".data"},   32'(lce_cmd), 32'(q[0]));
    check({ctx, ".count"},    32'(count),   32'(q.size()));
    check({ctx, ".empty"},    32'(empty),   32'(q.size() == 0));
    check({ctx, ".net_rdy"},  32'(net_rdy), 32'(m_init && q.size() <= N - 1));
    check({ctx, ".loop_rdy"}, 32'(loop_rdy), 32'(m_init && q.size() <= N - 2));
  endtask

  // One clock: check at the negedge, drive, update model, advance to the next negedge.
  task automatic cycle(input string ctx, input bit nv, input logic [W-1:0] nd,
                       input bit lv, input logic [W-1:0] ld, input bit yv);
    bit ne, le, y;
    check_outputs(ctx);
    ne = nv && m_init && (q.size() <= N - 1);
    le = lv && m_init && (q.size() <= N - 2);
    y  = yv && (q.size() != 0);
    net_v = nv; net_cmd = nd; loop_v = lv; loop_cmd = ld; yumi = y;
    if (y)  void'(q.pop_front());
    if (ne) q.push_back(nd);
    if (le) q.push_back(ld);
    @(negedge clk);
    m_init = 1'b1;
    net_v = 1'b0; loop_v = 1'b0; yumi = 1'b0;
  endtask

  initial begin
    // Reset release
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_outputs("reset");
      @(negedge clk);
    end
    reset_n = 1'b1;
    cycle("release", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check_outputs("post_release");

    // Single network command, yumi held high
    cycle("single_enq", 1'b1, 8'hA1, 1'b0, 8'h00, 1'b1);
    check("single.v", 32'(lce_v), 32'd1);
    check("single.data", 32'(lce_cmd), 32'hA1);
    cycle("single_deq", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("single.count", 32'(count), 32'd0);

    // Dual enqueue ordering
    cycle("dual_enq", 1'b1, 8'h10, 1'b1, 8'h20, 1'b0);
    check("dual.count", 32'(count), 32'd2);
    check("dual.first", 32'(lce_cmd), 32'h10);
    cycle("dual_d0", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("dual.second", 32'(lce_cmd), 32'h20);
    cycle("dual_d1", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Fill to full, with rejected valids at the thresholds
    cycle("fill0", 1'b1, 8'h31, 1'b1, 8'h32, 1'b0);
    cycle("fill1", 1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    check("fill.loop_rdy_at3", 32'(loop_rdy), 32'd0);
    check("fill.net_rdy_at3", 32'(net_rdy), 32'd1);
    cycle("fill2", 1'b1, 8'h34, 1'b1, 8'h35, 1'b0);
    check("fill.count_full", 32'(count), 32'd4);
    check("fill.net_rdy_at4", 32'(net_rdy), 32'd0);
    cycle("fill3", 1'b1, 8'h36, 1'b1, 8'h37, 1'b0);
    cycle("drain_to3", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cycle("yumi_net_at3", 1'b1, 8'h38, 1'b1, 8'h39, 1'b1);
    check("fill.count_stays3", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) cycle("fill_drain", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Wrap-around: 7 singles then a dual that straddles slot 3 / slot 0
    for (int i = 0; i < 7; i++) begin
      cycle("wrap_push", 1'b1, 8'(8'h40 + i), 1'b0, 8'h00, 1'b0);
      cycle("wrap_pop", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    end
    cycle("wrap_dual", 1'b1, 8'h5A, 1'b1, 8'h5B, 1'b0);
    check("wrap.first", 32'(lce_cmd), 32'h5A);
    cycle("wrap_d0", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("wrap.second", 32'(lce_cmd), 32'h5B);
    cycle("wrap_d1", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Mid-operation asynchronous reset with three entries stored
    cycle("mid_fill0", 1'b1, 8'h61, 1'b1, 8'h62, 1'b0);
    cycle("mid_fill1", 1'b1, 8'h63, 1'b0, 8'h00, 1'b0);
    check("mid.count3", 32'(count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    m_init = 1'b0;
    check("mid.v_drop", 32'(lce_v), 32'd0);
    check("mid.count0", 32'(count), 32'd0);
    check("mid.empty", 32'(empty), 32'd1);
    @(negedge clk);
    check_outputs("mid_in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    cycle("mid_release", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle("mid_idle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 2) != 0));
    check_outputs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_lce_cmd_ingress.md
# bp_lce_cmd_ingress

Ingress buffer for LCE commands in front of the LCE's command port. It accepts commands from two producers, the coherence network and the local LCE-to-LCE loopback, using ready->valid handshakes. It stores them in order in a circular FIFO and presents them to the LCE with the valid->yumi handshake the LCE command port requires. It also exports occupancy so tile logic can throttle or observe command backlog.

## Interface
Parameters:
- msg_width_p, 0 (must be overridden): width of one LCE command message (lce_cmd_msg_width_lp at instantiation).
- els_p, 4: FIFO depth; power of two, at least 2.
- lg_els_lp, `BSG_SAFE_CLOG2(els_p)` (localparam): pointer width.
- cnt_width_lp, `BSG_SAFE_CLOG2(els_p+1)` (localparam): count width.

Ports:
- clk_i, in, 1: clock; all state on the rising edge.
- reset_n_i, in, 1: reset; asynchronous, active-low.
- net_cmd_i, in, msg_width_p: command from the network.
- net_cmd_v_i, in, 1: net_cmd_i valid.
- net_cmd_ready_and_o, out, 1: network enqueue permitted.
- loop_cmd_i, in, msg_width_p: command from the local loopback path.
- loop_cmd_v_i, in, 1: loop_cmd_i valid.
- loop_cmd_ready_and_o, out, 1: loopback enqueue permitted.
- lce_cmd_o, out, msg_width_p: head command presented to the LCE.
- lce_cmd_v_o, out, 1: lce_cmd_o valid.
- lce_cmd_yumi_i, in, 1: LCE consumes lce_cmd_o this cycle.
- count_o, out, cnt_width_lp: current number of stored entries.
- empty_o, out, 1: count_o == 0.

## Operation
- State:
  - wptr_r, rptr_r: lg_els_lp bits each, wrap modulo els_p.
  - count_r: cnt_width_lp bits.
  - init_r: 1 bit; clears on reset and sets on the first clock edge after reset_n_i rises.
  - Storage: els_p × msg_width_p.
- Readiness never depends on any input valid:
  - net_cmd_ready_and_o = init_r & (count_r <= els_p-1).
  - loop_cmd_ready_and_o = init_r & (count_r <= els_p-2).
  - A dequeue in the current cycle does not raise readiness in that same cycle.
- Enqueue:
  - net_enq = net_cmd_v_i & net_cmd_ready_and_o.
  - loop_enq = loop_cmd_v_i & loop_cmd_ready_and_o.
- Ordering when both enqueue in one cycle:
  - The network entry is written at wptr_r and the loop entry at wptr_r+1.
  - wptr_r advances by 2.
  - Otherwise the single enqueue is written at wptr_r and wptr_r advances by 1.
- Dequeue:
  - lce_cmd_v_o = (count_r != 0) and lce_cmd_o = mem[rptr_r].
  - On lce_cmd_yumi_i, rptr_r advances by 1.
  - lce_cmd_yumi_i while lce_cmd_v_o is low is illegal; a simulation assertion flags it.
- Count update: count_r_next = count_r + net_enq + loop_enq − deq, with all terms extended to cnt_width_lp. It never exceeds els_p and never goes below 0.
- Simultaneous enqueue and dequeue at full or near-full:
  - Legal, because readiness is computed from the pre-dequeue count.
  - The count change is the net sum.
- Wrap-around: pointer arithmetic is modulo els_p. A dual write straddling the last slot writes slot els_p-1 and then slot 0.

## Timing
- Reset (reset_n_i low, takes effect asynchronously):
  - wptr_r, rptr_r, count_r and init_r go to 0.
  - lce_cmd_v_o=0, count_o=0, empty_o=1.
  - Both ready outputs are 0.
  - Storage contents are not reset.
- Readiness after reset: the ready outputs rise on the first edge after reset_n_i deasserts.
- Latency: an enqueue at edge N is visible on lce_cmd_o/lce_cmd_v_o after edge N (next cycle). There is no combinational path from inputs to outputs.
- Throughput: 2 enqueues and 1 dequeue per cycle maximum.
- Reset mid-operation: all stored commands are discarded. The producers must re-send, since coherence-level recovery is handled elsewhere.

## Configuration
- BP_LCE_CMD_INGRESS_BYPASS_EN: zero-latency bypass.
- When defined:
  - lce_cmd_v_o = (count_r != 0) | net_enq | loop_enq.
  - If count_r == 0, lce_cmd_o = net_cmd_i when net_enq, else loop_cmd_i.
  - A yumi in the same cycle consumes the presented command without writing it. The other command, if any, is written at wptr_r.
  - Readiness equations are unchanged.
- When undefined: behaviour is exactly as in Operation, with registered one-cycle latency.

## Test plan
- Reset release:
  - Stimulus: hold reset_n_i low 3 cycles, then release.
  - Required response: both ready outputs are 0 during reset and 1 one cycle after release; count_o=0; empty_o=1.
- Single network command:
  - Stimulus: enqueue net command 0xA1, with yumi held high.
  - Required response: lce_cmd_v_o=1 with 0xA1 the next cycle; count_o returns to 0.
  - With BYPASS_EN: 0xA1 appears in the same cycle.
- Dual enqueue ordering:
  - Stimulus: net 0x10 and loop 0x20 in the same cycle, then drain.
  - Required response: output order 0x10 then 0x20; count_o is 2 before draining.
- Fill to full (els_p=4):
  - Stimulus: fill with no yumi.
  - Required response: loop_ready drops at count 3 and net_ready drops at 4.
  - Then yumi plus net enqueue in the same cycle at count 3: count stays 3, and order is preserved.
- Wrap-around:
  - Stimulus: push and pop 7 singles, then a dual enqueue.
  - Required response: the slot 3/slot 0 straddle dequeues in net-then-loop order.
- Mid-operation reset:
  - Stimulus: assert reset_n_i asynchronously with count_o=3.
  - Required response: lce_cmd_v_o drops immediately and count_o=0; stale data is never presented after release.
